// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: consumer end of the ALU result interface.
// Accepted ALU results go into a small FIFO that feeds register-file writeback.
// The block also keeps a status register (sticky integer flags plus the FP
// condition code). Trapping integer overflows are not enqueued; each one
// produces a one-cycle ovf_exc pulse instead.
// Optional feature macro: ALU_WB_BYPASS_EN. When it is defined, a result
// can go straight to wb_* in the same cycle if the FIFO is empty and
// writeback is ready.
module alu_wb_buffer #(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] CMP_OP = 4'b1010,
    parameter logic [3:0] ADD_OP = 4'b0001,
    parameter logic [3:0] SUB_OP = 4'b0010
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                result,
    input  logic                       zero,
    input  logic                       overflow,
    input  logic                       carry_out,
    input  logic                       fp_cc,
    input  logic [3:0]                 alu_op,
    input  logic                       is_float,
    input  logic [4:0]                 dest_reg,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [31:0]                wb_data,
    output logic [4:0]                 wb_dest,
    output logic                       wb_fp,
    output logic                       wb_zero,
    output logic [3:0]                 status,
    input  logic                       clr_status,
    output logic                       ovf_exc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        fp;
        logic        zero;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic   sticky_ovf;
    logic   sticky_carry;
    logic   sticky_zero;
    logic   fp_cc_reg;
    logic   ovf_exc_q;

    logic   accept;
    logic   trap;
    logic   bypass;
    logic   push;
    logic   pop;
    logic   fifo_valid;
    entry_t head;
    entry_t in_entry;

    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign accept     = in_valid & in_ready;
    assign trap       = accept & ~is_float & overflow &
                        ((alu_op == ADD_OP) | (alu_op == SUB_OP));
    assign fifo_valid = (count_q != '0);
    assign head       = mem[rd_ptr];
    assign in_entry   = '{data: result, dest: dest_reg, fp: is_float, zero: zero};

`ifdef ALU_WB_BYPASS_EN
    // An empty FIFO with writeback ready forwards the result in the same cycle.
    assign bypass = accept & ~trap & ~fifo_valid & wb_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~trap & ~bypass;
    assign pop  = fifo_valid & wb_ready;

    // Writeback port: the registered head entry, or the live input while bypassing.
    always_comb begin
        // NOTE: every output gets a default first, so no path through this block leaves a latch.
        wb_valid = fifo_valid;
        wb_data  = head.data;
        wb_dest  = head.dest;
        wb_fp    = head.fp;
        wb_zero  = head.zero;
        if (bypass) begin
            wb_valid = 1'b1;
            wb_data  = in_entry.data;
            wb_dest  = in_entry.dest;
            wb_fp    = in_entry.fp;
            wb_zero  = in_entry.zero;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too, because the head entry drives wb_* directly and must read as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this block order-independent.
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Status register: sticky flags are cleared by clr_status; fp_cc_reg is updated by FP compares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf   <= 1'b0;
            sticky_carry <= 1'b0;
            sticky_zero  <= 1'b0;
            fp_cc_reg    <= 1'b0;
        end else begin
            if (clr_status) begin
                sticky_ovf   <= 1'b0;
                sticky_carry <= 1'b0;
                sticky_zero  <= 1'b0;
            end else if (accept) begin
                sticky_ovf   <= sticky_ovf   | (overflow  & ~is_float);
                sticky_carry <= sticky_carry | (carry_out & ~is_float);
                sticky_zero  <= sticky_zero  | zero;
            end
            if (accept && is_float && (alu_op == CMP_OP)) begin
                fp_cc_reg <= fp_cc;
            end
        end
    end

    // One-cycle exception pulse for each trapped overflow that is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_exc_q <= 1'b0;
        end else begin
            ovf_exc_q <= trap;
        end
    end

    assign status  = {fp_cc_reg, sticky_zero, sticky_carry, sticky_ovf};
    assign ovf_exc = ovf_exc_q;
    assign count   = count_q;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed testbench for alu_wb_buffer with DEPTH=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_wb_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        carry_out;
    logic        fp_cc;
    logic [3:0]  alu_op;
    logic        is_float;
    logic [4:0]  dest_reg;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        wb_fp;
    logic        wb_zero;
    logic [3:0]  status;
    logic        clr_status;
    logic        ovf_exc;
    logic [2:0]  count;

    int n_pass  = 0;
    int n_total = 0;

    alu_wb_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .carry_out  (carry_out),
        .fp_cc      (fp_cc),
        .alu_op     (alu_op),
        .is_float   (is_float),
        .dest_reg   (dest_reg),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_dest    (wb_dest),
        .wb_fp      (wb_fp),
        .wb_zero    (wb_zero),
        .status     (status),
        .clr_status (clr_status),
        .ovf_exc    (ovf_exc),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        result     = '0;
        zero       = 1'b0;
        overflow   = 1'b0;
        carry_out  = 1'b0;
        fp_cc      = 1'b0;
        alu_op     = 4'b0001;
        is_float   = 1'b0;
        dest_reg   = '0;
        clr_status = 1'b0;
    endtask

    task automatic drive(input logic [31:0] r, input logic z, input logic ov,
                         input logic c, input logic cc, input logic [3:0] op,
                         input logic f, input logic [4:0] d);
        in_valid  = 1'b1;
        result    = r;
        zero      = z;
        overflow  = ov;
        carry_out = c;
        fp_cc     = cc;
        alu_op    = op;
        is_float  = f;
        dest_reg  = d;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        wb_ready = 1'b0;
        idle();
        #12;
        n_total++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b exp 0", wb_valid); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL rst_count: got %0d exp 0", count); else n_pass++;
        n_total++; if (status !== 4'b0000) $display("FAIL rst_status: got %b exp 0000", status); else n_pass++;
        n_total++; if (wb_data !== 32'h0) $display("FAIL rst_wb_data: got %h exp 0", wb_data); else n_pass++;
        n_total++; if (ovf_exc !== 1'b0) $display("FAIL rst_ovf_exc: got %b exp 0", ovf_exc); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_int_add();
        wb_ready = 1'b1;
        drive(32'h00000030, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 5'd3);
        step();
        idle();
        n_total++; if (wb_valid !== 1'b1) $display("FAIL add_wb_valid: got %b exp 1", wb_valid); else n_pass++;
        n_total++; if (wb_data !== 32'h00000030) $display("FAIL add_wb_data: got %h exp 00000030", wb_data); else n_pass++;
        n_total++; if (wb_dest !== 5'd3) $display("FAIL add_wb_dest: got %0d exp 3", wb_dest); else n_pass++;
        n_total++; if (wb_fp !== 1'b0) $display("FAIL add_wb_fp: got %b exp 0", wb_fp); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL add_count1: got %0d exp 1", count); else n_pass++;
        step();
        n_total++; if (count !== 3'd0) $display("FAIL add_count0: got %0d exp 0", count); else n_pass++;
        n_total++; if (wb_valid !== 1'b0) $display("FAIL add_empty: got %b exp 0", wb_valid); else n_pass++;
    endtask

    task automatic test_trap();
        wb_ready = 1'b1;
        drive(32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 5'd4);
        step();
        idle();
        n_total++; if (ovf_exc !== 1'b1) $display("FAIL trap_exc_hi: got %b exp 1", ovf_exc); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL trap_count: got %0d exp 0", count); else n_pass++;
        n_total++; if (wb_valid !== 1'b0) $display("FAIL trap_wb_valid: got %b exp 0", wb_valid); else n_pass++;
        n_total++; if (status !== 4'b0001) $display("FAIL trap_status: got %b exp 0001", status); else n_pass++;
        step();
        n_total++; if (ovf_exc !== 1'b0) $display("FAIL trap_exc_lo: got %b exp 0", ovf_exc); else n_pass++;
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        n_total++; if (status !== 4'b0000) $display("FAIL trap_clr: got %b exp 0000", status); else n_pass++;
        // A non-trapping op (SUB on FP) with overflow set must still be enqueued.
        drive(32'h11223344, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 5'd9);
        step();
        idle();
        n_total++; if (ovf_exc !== 1'b0) $display("FAIL fp_ovf_exc: got %b exp 0", ovf_exc); else n_pass++;
        n_total++; if (wb_data !== 32'h11223344) $display("FAIL fp_ovf_data: got %h exp 11223344", wb_data); else n_pass++;
        n_total++; if (status !== 4'b0000) $display("FAIL fp_ovf_status: got %b exp 0000", status); else n_pass++;
        step();
    endtask

    task automatic test_fp_cmp();
        wb_ready = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 5'd1);
        step();
        n_total++; if (status !== 4'b1000) $display("FAIL cmp_status: got %b exp 1000", status); else n_pass++;
        drive(32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 5'd7);
        step();
        idle();
        n_total++; if (status !== 4'b1000) $display("FAIL fpadd_status: got %b exp 1000", status); else n_pass++;
        n_total++; if (wb_data !== 32'h40400000) $display("FAIL fpadd_data: got %h exp 40400000", wb_data); else n_pass++;
        n_total++; if (wb_fp !== 1'b1) $display("FAIL fpadd_fp: got %b exp 1", wb_fp); else n_pass++;
        n_total++; if (wb_dest !== 5'd7) $display("FAIL fpadd_dest: got %0d exp 7", wb_dest); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL fpadd_count: got %0d exp 1", count); else n_pass++;
        // Clearing the sticky bits leaves fp_cc_reg unchanged.
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        n_total++; if (status !== 4'b1000) $display("FAIL clr_keeps_cc: got %b exp 1000", status); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL fp_drain: got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 5'(i));
            step();
            if (i == 4) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b exp 0", in_ready); else n_pass++;
                n_total++; if (count !== 3'd4) $display("FAIL bp_count4: got %0d exp 4", count); else n_pass++;
            end
        end
        n_total++; if (count !== 3'd4) $display("FAIL bp_held: got %0d exp 4", count); else n_pass++;
        n_total++; if (wb_data !== 32'd1) $display("FAIL bp_head_stable: got %0d exp 1", wb_data); else n_pass++;
        wb_ready = 1'b1;
        n_total++; if (wb_data !== 32'd1) $display("FAIL bp_drain1: got %0d exp 1", wb_data); else n_pass++;
        step();
        n_total++; if (count !== 3'd3) $display("FAIL bp_count3: got %0d exp 3", count); else n_pass++;
        n_total++; if (wb_data !== 32'd2) $display("FAIL bp_drain2: got %0d exp 2", wb_data); else n_pass++;
        step();
        idle();
        n_total++; if (count !== 3'd3) $display("FAIL bp_pushpop: got %0d exp 3", count); else n_pass++;
        for (int k = 3; k <= 5; k++) begin
            n_total++; if (wb_valid !== 1'b1 || wb_data !== 32'(k)) $display("FAIL bp_drain%0d: got v=%b d=%0d exp v=1 d=%0d", k, wb_valid, wb_data, k); else n_pass++;
            step();
        end
        n_total++; if (count !== 3'd0 || wb_valid !== 1'b0) $display("FAIL bp_empty: got count=%0d v=%b exp 0/0", count, wb_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        wb_ready = 1'b0;
        drive(32'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 5'd10);
        step();
        drive(32'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 5'd11);
        step();
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        n_total++; if (count !== 3'd2) $display("FAIL b2b_count_init: got %0d exp 2", count); else n_pass++;
        wb_ready = 1'b1;
        for (int i = 2; i <= 3; i++) begin
            drive(32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 5'(10 + i));
            step();
            void'(exp_q.pop_front());
            n_total++; if (count !== 3'd2) $display("FAIL b2b_count%0d: got %0d exp 2", i, count); else n_pass++;
            n_total++; if (wb_data !== exp_q[0]) $display("FAIL b2b_order%0d: got %h exp %h", i, wb_data, exp_q[0]); else n_pass++;
        end
        idle();
        step();
        void'(exp_q.pop_front());
        n_total++; if (wb_data !== exp_q[0] || wb_dest !== 5'd13) $display("FAIL b2b_last: got %h/%0d exp %h/13", wb_data, wb_dest, exp_q[0]); else n_pass++;
        step();
        n_total++; if (count !== 3'd0) $display("FAIL b2b_empty: got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'hBEEF0000 + 32'(i), 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 5'(20 + i));
            step();
        end
        n_total++; if (count !== 3'd3 || status !== 4'b1110) $display("FAIL mid_pre: got count=%0d st=%b exp 3/1110", count, status); else n_pass++;
        // A trapped op is pending when reset hits and must not pulse afterwards.
        drive(32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 5'd5);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (wb_valid !== 1'b0) $display("FAIL mid_wb_valid: got %b exp 0", wb_valid); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL mid_count: got %0d exp 0", count); else n_pass++;
        n_total++; if (status !== 4'b0000) $display("FAIL mid_status: got %b exp 0000", status); else n_pass++;
        idle();
        step();
        rst_n = 1'b1;
        step();
        n_total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b exp 1", in_ready); else n_pass++;
        n_total++; if (ovf_exc !== 1'b0) $display("FAIL mid_ovf_exc: got %b exp 0", ovf_exc); else n_pass++;
        n_total++; if (wb_valid !== 1'b0 || wb_data !== 32'h0) $display("FAIL mid_stale: got v=%b d=%h exp 0/0", wb_valid, wb_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_int_add();
        test_trap();
        test_fp_cmp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Consumer end of the ALU result interface. Captures per-operation ALU outputs (result, zero, overflow, carry_out, fp_cc) on a valid/ready handshake and queues them in a small FIFO for register-file writeback.
- Maintains a status register: sticky integer flags plus the FP condition code.
- Filters trapping integer-overflow results into a one-cycle exception pulse.
- Sits between the execute stage (ALU) and the writeback stage.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CMP_OP, 4'b1010, alu_op code that updates the fp_cc status bit when is_float=1.
- ADD_OP, 4'b0001, integer add code, trapping on overflow.
- SUB_OP, 4'b0010, integer subtract code, trapping on overflow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  buffer can accept.
- result  in  32  ALU result.
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU overflow flag.
- carry_out  in  1  ALU carry flag.
- fp_cc  in  1  ALU FP compare condition.
- alu_op  in  4  operation code of this result.
- is_float  in  1  FP operation.
- dest_reg  in  5  destination register index.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  writeback accepts.
- wb_data  out  32  head result.
- wb_dest  out  5  head destination.
- wb_fp  out  1  head targets FP register file.
- wb_zero  out  1  head zero flag.
- status  out  4  {fp_cc_reg, sticky_zero, sticky_carry, sticky_ovf}.
- clr_status  in  1  synchronous clear of the sticky bits (fp_cc_reg is kept).
- ovf_exc  out  1  one-cycle pulse when a trapping overflow is dropped.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, count=0, wb_valid=0, wb_data=0, wb_dest=0, wb_fp=0, wb_zero=0, status=4'b0000, ovf_exc=0, in_ready=1 after reset release.
- Accept = in_valid & in_ready. in_ready = (count != DEPTH); it depends only on registered state, not on wb_ready.
- Trap filter: an accepted op with is_float=0, overflow=1 and alu_op in {ADD_OP, SUB_OP} is not enqueued. ovf_exc=1 in the next cycle only, and sticky_ovf is set.
- All other accepted ops are enqueued with {result, dest_reg, is_float, zero}.
- Latency: an entry is visible on wb_* one cycle after accept. wb_* come from registered head storage; no combinational in->out path (except under the optional feature).
- Pop = wb_valid & wb_ready; head advances at the clock edge. wb_* hold stable while wb_valid=1 and wb_ready=0.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
- Full: push blocked by in_ready=0; a pop in that cycle frees space for the next cycle.
- Empty: wb_valid=0; wb_data holds its last value (don't-care).
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Status update on every accept (trapped ones included):
  - sticky_ovf |= overflow & ~is_float.
  - sticky_carry |= carry_out & ~is_float.
  - sticky_zero |= zero.
  - fp_cc_reg <= fp_cc when is_float=1 and alu_op==CMP_OP.
- clr_status in the same cycle as an accept: clear wins for the sticky bits; fp_cc_reg still updates.
- Reset mid-operation: all entries discarded immediately; no ovf_exc pulse is produced after reset deasserts.

Optional Feature:
- Macro ALU_WB_BYPASS_EN.
- Defined: when count==0, in_valid=1, the op is not trapped and wb_ready=1, the result passes combinationally to wb_* with wb_valid=1 in the same cycle and is not enqueued. Status and count update as normal (count stays 0).
- Not defined: strict one-cycle minimum latency through the FIFO; no combinational path from in_* to wb_*.

Test Plan:
- Integer add: result 32'h00000030, dest_reg=3, wb_ready=1 -> next cycle wb_valid=1, wb_data=32'h00000030, wb_dest=3, wb_fp=0; count returns to 0 after the pop.
- Trapped add: a=32'h7FFFFFFF+1 gives result 32'h80000000 with overflow=1, alu_op=0001, is_float=0 -> nothing enqueued, ovf_exc high exactly one cycle, status[0]=1; clr_status then gives status[0]=0.
- FP compare: alu_op=1010, is_float=1, fp_cc=1 -> status[3]=1. A following FP add (alu_op=0001, result 32'h40400000) leaves status[3]=1 and enqueues wb_data=32'h40400000, wb_fp=1.
- Backpressure: wb_ready=0, push 5 results 1..5 with DEPTH=4 -> in_ready falls after the 4th, count=4, 5th held. Raising wb_ready drains 1,2,3,4 then 5, in order.
- Simultaneous push/pop at count=2 -> count stays 2, order preserved across pointer wrap.
- Assert rst_n low with 3 entries queued -> wb_valid=0, count=0, status=0 asynchronously; after release, in_ready=1 and no stale data appears.
